// File: rtl/bch_pkg.sv
// Shared types and constants for the BCH GF(2^m) math layer.
// Provides the divider FSM state, default primitive polynomials and the divider latency.
package bch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSqr,
        StMul,
        StDone
    } div_state_e;

    // Low m coefficients of a primitive polynomial for GF(2^m); x^m is implied.
    function automatic logic [31:0] prim_poly_low(input int unsigned m);
        logic [31:0] p;
        p = 32'h0000_0003;
        case (m)
            2, 3, 4, 6, 15, 22:      p = 32'h0000_0003;
            5, 11, 21, 29:           p = 32'h0000_0005;
            7, 10, 17, 20, 25, 28:   p = 32'h0000_0009;
            31:                      p = 32'h0000_0009;
            8:                       p = 32'h0000_001D;
            9:                       p = 32'h0000_0011;
            12, 30:                  p = 32'h0000_0053;
            13:                      p = 32'h0000_001B;
            14:                      p = 32'h0000_002B;
            16:                      p = 32'h0000_100B;
            18:                      p = 32'h0000_0081;
            19, 27:                  p = 32'h0000_0027;
            23:                      p = 32'h0000_0021;
            24:                      p = 32'h0000_0087;
            26:                      p = 32'h0000_0047;
            default:                 p = 32'h0000_0003;
        endcase
        return p;
    endfunction

    // Accept edge to the edge at which the quotient is sampled valid.
    function automatic int unsigned div_latency(input int unsigned m);
        return 2 * (m - 1) * (m + 1) + 1;
    endfunction

endpackage

// File: rtl/bch_gf_mul_serial.sv
// Bit-serial MSB-first GF(2^m) multiplier: one load cycle, then m shift cycles.
// done_o flags the last shift cycle; p_o then carries the product to be captured on that edge.
module bch_gf_mul_serial #(
    parameter int unsigned       Width = 8,
    parameter logic [Width-1:0]  Poly  = Width'(8'h1D)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    output logic [Width-1:0] p_o,
    output logic             done_o
);

    localparam int unsigned CntW = $clog2(Width + 1);

    logic [Width-1:0] acc_q, acc_d;
    logic [Width-1:0] a_q, a_d;
    logic [Width-1:0] b_q, b_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [Width-1:0] acc_shift;

    always_comb begin
        acc_shift = {acc_q[Width-2:0], 1'b0}
                  ^ (acc_q[Width-1] ? Poly : '0)
                  ^ (b_q[Width-1] ? a_q : '0);
        acc_d = acc_q;
        a_d   = a_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        if (start_i) begin
            a_d   = a_i;
            b_d   = b_i;
            acc_d = '0;
            cnt_d = CntW'(Width);
        end else if (cnt_q != '0) begin
            acc_d = acc_shift;
            b_d   = {b_q[Width-2:0], 1'b0};
            cnt_d = cnt_q - 1'b1;
        end
        p_o    = acc_shift;
        done_o = (cnt_q == CntW'(1));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            a_q   <= a_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bch_math_div.sv
// Iterative GF(2^m) divider: Q = A * B^(2^m-2) via square-and-multiply on one serial multiplier.
// Optional macro BCH_DIV_ZERO_CHK_EN short-cuts B=0 straight to a flagged result.
module bch_math_div
    import bch_pkg::*;
#(
    parameter int unsigned          C_INWIDTH   = 8,
    parameter logic [C_INWIDTH-1:0] C_POLY_PRIM = C_INWIDTH'(prim_poly_low(C_INWIDTH))
) (
    input  logic                 I_clk,
    input  logic                 I_rst_n,
    input  logic [C_INWIDTH-1:0] I_Dividend,
    input  logic [C_INWIDTH-1:0] I_Divisor,
    input  logic                 I_Div_v,
    output logic                 O_Busy,
    output logic [C_INWIDTH-1:0] O_Quot,
    output logic                 O_Quot_v,
    output logic                 O_Err
);

    localparam int unsigned KW = $clog2(C_INWIDTH);

    div_state_e           state_q, state_d;
    logic [C_INWIDTH-1:0] r_q, r_d;
    logic [C_INWIDTH-1:0] s_q, s_d;
    logic [KW-1:0]        k_q, k_d;
    logic                 run_q, run_d;
    logic [C_INWIDTH-1:0] quot_q, quot_d;
    logic                 quot_v_q, quot_v_d;
    logic                 err_q, err_d;

    logic                 mul_start;
    logic [C_INWIDTH-1:0] mul_a, mul_b, mul_p;
    logic                 mul_done;

    bch_gf_mul_serial #(
        .Width (C_INWIDTH),
        .Poly  (C_POLY_PRIM)
    ) u_mul (
        .clk_i   (I_clk),
        .rst_ni  (I_rst_n),
        .start_i (mul_start),
        .a_i     (mul_a),
        .b_i     (mul_b),
        .p_o     (mul_p),
        .done_o  (mul_done)
    );

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        s_d       = s_q;
        k_d       = k_q;
        run_d     = run_q;
        quot_d    = quot_q;
        quot_v_d  = 1'b0;
        err_d     = err_q;
        mul_start = 1'b0;
        mul_a     = s_q;
        mul_b     = (state_q == StMul) ? r_q : s_q;

        unique case (state_q)
            StIdle: begin
                if (I_Div_v) begin
                    r_d     = I_Dividend;
                    s_d     = I_Divisor;
                    k_d     = KW'(1);
                    state_d = StSqr;
`ifdef BCH_DIV_ZERO_CHK_EN
                    if (I_Divisor == '0) begin
                        state_d  = StDone;
                        quot_d   = '0;
                        quot_v_d = 1'b1;
                        err_d    = 1'b1;
                    end
`endif
                end
            end
            StSqr: begin
                if (!run_q) begin
                    mul_start = 1'b1;
                    run_d     = 1'b1;
                end else if (mul_done) begin
                    s_d     = mul_p;
                    run_d   = 1'b0;
                    state_d = StMul;
                end
            end
            StMul: begin
                if (!run_q) begin
                    mul_start = 1'b1;
                    run_d     = 1'b1;
                end else if (mul_done) begin
                    r_d   = mul_p;
                    run_d = 1'b0;
                    if (k_q == KW'(C_INWIDTH - 1)) begin
                        // Quotient and valid are registered here so they are live during DONE.
                        state_d  = StDone;
                        quot_d   = mul_p;
                        quot_v_d = 1'b1;
                        err_d    = 1'b0;
                    end else begin
                        k_d     = k_q + KW'(1);
                        state_d = StSqr;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q  <= StIdle;
            r_q      <= '0;
            s_q      <= '0;
            k_q      <= '0;
            run_q    <= 1'b0;
            quot_q   <= '0;
            quot_v_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            s_q      <= s_d;
            k_q      <= k_d;
            run_q    <= run_d;
            quot_q   <= quot_d;
            quot_v_q <= quot_v_d;
            err_q    <= err_d;
        end
    end

    assign O_Busy   = (state_q != StIdle);
    assign O_Quot   = quot_q;
    assign O_Quot_v = quot_v_q;
`ifdef BCH_DIV_ZERO_CHK_EN
    assign O_Err    = err_q;
`else
    assign O_Err    = 1'b0 & err_q;
`endif

endmodule

// File: doc/bch_math_div.md
# bch_math_div

Iterative GF(2^m) divider for the BCH datapath. It computes Q = A / B as A · B^(2^m−2), using Fermat inversion by repeated square-and-multiply over one shared bit-serial GF multiplier. It sits beside the serial multiplier in the decoder math layer and serves error-locator and error-value steps that need a field inverse. A single request/valid handshake is used, with one operation in flight.

## Interface
Parameters:
- C_INWIDTH, 8: field degree m (supported range 2..31).
- C_POLY_PRIM, 8'h1D: low m coefficients of the primitive polynomial, x^m implied. The default gives 0x11D.

Ports:
- I_clk  in  1: clock; all logic on rising edge.
- I_rst_n  in  1: reset, asynchronous active-low.
- I_Dividend  in  C_INWIDTH: A.
- I_Divisor  in  C_INWIDTH: B.
- I_Div_v  in  1: request strobe; accepted only when O_Busy=0.
- O_Busy  out  C_INWIDTH→1: high from the accept edge through the O_Quot_v cycle inclusive.
- O_Quot  out  C_INWIDTH: quotient; holds its value until the next result.
- O_Quot_v  out  1: one-cycle pulse, quotient valid.
- O_Err  out  1: divide-by-zero flag, qualified by O_Quot_v.

## Operation
- Reset values: O_Quot=0, O_Quot_v=0, O_Busy=0, O_Err=0, FSM=IDLE, all internal registers 0.
- **IDLE**
  - On I_Div_v=1, latch R←A and S←B, set O_Busy, then go to SQR.
  - I_Div_v while busy is ignored; there is no queueing.
- **Rounds:** a round counter k runs 1..m−1.
  - **SQR:** S←S·S.
  - **MUL:** R←R·S.
  - After MUL, if k=m−1 go to DONE; otherwise k←k+1 and go to SQR.
- **DONE:** O_Quot←R, pulse O_Quot_v, clear O_Busy, return to IDLE.
- **Multiply sub-op** (each SQR or MUL), m+1 cycles:
  - 1 load cycle: operands into the multiplier, accumulator cleared.
  - m shift cycles, MSB-first: acc←(acc<<1) ⊕ (acc[m−1]·POLY) ⊕ (mult_bit·multiplicand).
  - The result is registered into S or R on the last shift edge.
- **Arithmetic:** all ops are modulo the primitive polynomial; no intermediate value ever exceeds m bits.
- **Boundaries:**
  - A=0 gives Q=0 with full latency.
  - B=1 gives Q=A.
  - B=0, without the config macro: runs the full sequence and Q=0 falls out naturally, with O_Err=0.
  - A new I_Div_v in the same cycle as DONE is ignored; it is accepted from the next cycle.
  - Reset asserted mid-operation aborts immediately to reset values, with no O_Quot_v.

## Timing
- Accept edge = cycle 0. Each sub-op takes m+1 cycles, and there are 2(m−1) sub-ops.
- O_Quot_v is high in cycle 2(m−1)(m+1)+1. For m=8 that is cycle 127.
- Throughput: one result per 2(m−1)(m+1)+2 cycles at back-to-back requests (128 for m=8).
- Inputs are sampled only at the accept edge; they may change afterwards.

## Configuration
- BCH_DIV_ZERO_CHK_EN defined:
  - B=0 at accept goes IDLE→DONE directly.
  - O_Quot=0, O_Err=1, O_Quot_v in cycle 1, O_Busy high only in cycle 1.
- Not defined:
  - No zero detect; O_Err is tied 0.
  - B=0 takes full latency with Q=0.

## Structure
- **Package bch_pkg:**
  - FSM state enum (IDLE, SQR, MUL, DONE).
  - Default C_POLY_PRIM constants per supported m.
  - Latency constant function 2(m−1)(m+1)+1.
- **Sub-module bch_gf_mul_serial** (m+1-cycle load/shift multiplier with start/done):
  - Instantiated once.
  - Operands muxed by the FSM: S,S in SQR; R,S in MUL.

## Test plan
- m=8, A=0x01, B=0x01 → O_Quot=0x01, O_Quot_v exactly at cycle 127, O_Err=0.
- A=0x03, B=0x02 → O_Quot=0x8F. A=0x01, B=0x02 → O_Quot=0x8E.
- B=0x00:
  - With BCH_DIV_ZERO_CHK_EN → O_Quot=0, O_Err=1, valid at cycle 1.
  - Without it → O_Quot=0, O_Err=0, valid at cycle 127.
- I_Div_v held high continuously with changing operands → only the operands at each accept are used. Results arrive 128 cycles apart, and O_Busy never drops outside the valid cycle.
- Deassert I_rst_n at cycle 60 of an op → all outputs 0 immediately, no O_Quot_v. The next request completes correctly.
- 1000 random nonzero (A,B) pairs → O_Quot·B=A, checked against a reference GF multiply model.
